// File: rtl/bp_update_sched.sv
// bp_update_sched: merges two branch-resolution ports into a FIFO feeding the predictor update port and runs table clears
module bp_update_sched #(
  parameter int ABITS = 10,
  parameter int DEPTH = 4
) (
  input  logic                         clock_i,
  input  logic                         reset_n_i,
  input  logic                         res0_valid_i,
  input  logic [31:0]                  res0_pc_i,
  input  logic [31:0]                  res0_tgt_i,
  input  logic                         res0_taken_i,
  input  logic                         res0_br_i,
  input  logic                         res0_btb_i,
  input  logic                         res1_valid_i,
  input  logic [31:0]                  res1_pc_i,
  input  logic [31:0]                  res1_tgt_i,
  input  logic                         res1_taken_i,
  input  logic                         res1_br_i,
  input  logic                         res1_btb_i,
  output logic                         res_ready_o,
  input  logic                         clear_i,
  output logic                         upd_valid_o,
  output logic [31:0]                  upd_pc_o,
  output logic [31:0]                  upd_tgt_o,
  output logic                         upd_taken_o,
  output logic                         upd_pht_o,
  output logic                         upd_btb_o,
  input  logic                         upd_ready_i,
  output logic                         clr_we_o,
  output logic [ABITS-1:0]             clr_idx_o,
  output logic                         busy_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         drop_o
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);
  typedef enum logic {CLEAR, RUN} state_t;
  state_t state, state_n;
  logic [ABITS-1:0] idx, idx_n;
  logic [66:0] mem [DEPTH];
  logic [PW-1:0] wp, rp;
  logic [CW-1:0] count;
  logic drop, run, flush, push0, push1, pop;
  assign run = state == RUN;
  assign flush = run && clear_i;
  assign res_ready_o = run && (count <= CW'(DEPTH - 2));
  assign push0 = res_ready_o && res0_valid_i && !clear_i;
  assign push1 = res_ready_o && res1_valid_i && !clear_i;
  assign upd_valid_o = run && (count != '0);
  assign pop = upd_valid_o && upd_ready_i && !clear_i;
  assign {upd_pc_o, upd_tgt_o, upd_taken_o, upd_pht_o, upd_btb_o} = mem[rp];
  assign clr_we_o = !run;
  assign busy_o = !run;
  assign clr_idx_o = idx;
  assign count_o = count;
  assign drop_o = drop;
  always_comb begin
    state_n = run ? (clear_i ? CLEAR : RUN) : (idx == '1 ? RUN : CLEAR);
    idx_n = run ? '0 : idx + 1'b1;
  end
  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      state <= CLEAR;
      idx <= '0;
    end else begin
      state <= state_n;
      idx <= idx_n;
    end
  end
  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
      drop <= 1'b0;
    end else begin
      drop <= (res0_valid_i || res1_valid_i) && !res_ready_o;
      if (flush) begin
        wp <= '0;
        rp <= '0;
        count <= '0;
      end else begin
        wp <= wp + PW'(push0) + PW'(push1);
        rp <= rp + PW'(pop);
        count <= count + CW'(push0) + CW'(push1) - CW'(pop);
      end
    end
  end
  always_ff @(posedge clock_i) begin
    if (push0) mem[wp] <= {res0_pc_i, res0_tgt_i, res0_taken_i, res0_br_i, res0_btb_i};
    if (push1) mem[push0 ? wp + 1'b1 : wp] <= {res1_pc_i, res1_tgt_i, res1_taken_i, res1_br_i, res1_btb_i};
  end
endmodule

// File: tb/tb_bp_update_sched.sv
// tb_bp_update_sched: directed scoreboard bench for bp_update_sched
module tb_bp_update_sched;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] tgt;
    logic taken;
    logic br;
    logic btb;
  } ent_t;
  logic clk = 1'b0;
  logic reset_n;
  logic res0_valid, res0_taken, res0_br, res0_btb;
  logic [31:0] res0_pc, res0_tgt;
  logic res1_valid, res1_taken, res1_br, res1_btb;
  logic [31:0] res1_pc, res1_tgt;
  logic res_ready, clear, upd_valid, upd_taken, upd_pht, upd_btb, upd_ready;
  logic [31:0] upd_pc, upd_tgt;
  logic clr_we, busy, drop;
  logic [3:0] clr_idx;
  logic [2:0] count;
  ent_t sb[$];
  int n_assert = 0;
  int n_fail = 0;
  bp_update_sched #(.ABITS(4), .DEPTH(4)) dut (
    .clock_i(clk), .reset_n_i(reset_n),
    .res0_valid_i(res0_valid), .res0_pc_i(res0_pc), .res0_tgt_i(res0_tgt),
    .res0_taken_i(res0_taken), .res0_br_i(res0_br), .res0_btb_i(res0_btb),
    .res1_valid_i(res1_valid), .res1_pc_i(res1_pc), .res1_tgt_i(res1_tgt),
    .res1_taken_i(res1_taken), .res1_br_i(res1_br), .res1_btb_i(res1_btb),
    .res_ready_o(res_ready), .clear_i(clear),
    .upd_valid_o(upd_valid), .upd_pc_o(upd_pc), .upd_tgt_o(upd_tgt),
    .upd_taken_o(upd_taken), .upd_pht_o(upd_pht), .upd_btb_o(upd_btb),
    .upd_ready_i(upd_ready), .clr_we_o(clr_we), .clr_idx_o(clr_idx),
    .busy_o(busy), .count_o(count), .drop_o(drop)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    ent_t e;
    if (upd_valid && upd_ready) begin
      if (sb.size() == 0) chk("pop_unexpected", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        chk("pop_pc", upd_pc, e.pc);
        chk("pop_tgt", upd_tgt, e.tgt);
        chk("pop_taken", {31'd0, upd_taken}, {31'd0, e.taken});
        chk("pop_pht", {31'd0, upd_pht}, {31'd0, e.br});
        chk("pop_btb", {31'd0, upd_btb}, {31'd0, e.btb});
      end
    end
    @(posedge clk);
    #1;
  endtask
  task automatic drive0(input logic v, input ent_t e, input logic expect_push);
    res0_valid = v;
    {res0_pc, res0_tgt, res0_taken, res0_br, res0_btb} = e;
    if (v && expect_push) sb.push_back(e);
  endtask
  task automatic drive1(input logic v, input ent_t e, input logic expect_push);
    res1_valid = v;
    {res1_pc, res1_tgt, res1_taken, res1_br, res1_btb} = e;
    if (v && expect_push) sb.push_back(e);
  endtask
  task automatic idle();
    res0_valid = 1'b0;
    res1_valid = 1'b0;
  endtask
  task automatic run_clear(input string tag);
    for (int i = 0; i < 16; i++) begin
      chk({tag, "_we"}, {31'd0, clr_we}, 32'd1);
      chk({tag, "_idx"}, {28'd0, clr_idx}, i);
      chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
      chk({tag, "_updv"}, {31'd0, upd_valid}, 32'd0);
      tick();
    end
    chk({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
    chk({tag, "_we_end"}, {31'd0, clr_we}, 32'd0);
    chk({tag, "_ready_end"}, {31'd0, res_ready}, 32'd1);
    chk({tag, "_count_end"}, {29'd0, count}, 32'd0);
  endtask
  initial begin
    reset_n = 1'b0;
    clear = 1'b0;
    upd_ready = 1'b0;
    drive0(1'b0, '0, 1'b0);
    drive1(1'b0, '0, 1'b0);
    tick();
    tick();
    chk("rst_count", {29'd0, count}, 32'd0);
    chk("rst_updv", {31'd0, upd_valid}, 32'd0);
    chk("rst_ready", {31'd0, res_ready}, 32'd0);
    chk("rst_drop", {31'd0, drop}, 32'd0);
    reset_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("clr0_we", {31'd0, clr_we}, 32'd1);
      chk("clr0_idx", {28'd0, clr_idx}, i);
      chk("clr0_busy", {31'd0, busy}, 32'd1);
      chk("clr0_ready", {31'd0, res_ready}, 32'd0);
      if (i == 4) chk("clr0_drop", {31'd0, drop}, 32'd1);
      if (i == 5) chk("clr0_drop_off", {31'd0, drop}, 32'd0);
      res0_valid = (i == 3);
      tick();
    end
    idle();
    chk("run_busy", {31'd0, busy}, 32'd0);
    chk("run_ready", {31'd0, res_ready}, 32'd1);
    chk("run_count", {29'd0, count}, 32'd0);
    upd_ready = 1'b1;
    drive0(1'b1, '{32'h100, 32'h200, 1'b1, 1'b1, 1'b0}, 1'b1);
    drive1(1'b1, '{32'h104, 32'h300, 1'b0, 1'b0, 1'b1}, 1'b1);
    tick();
    idle();
    chk("dual_count2", {29'd0, count}, 32'd2);
    chk("dual_head", upd_pc, 32'h100);
    tick();
    chk("dual_count1", {29'd0, count}, 32'd1);
    tick();
    chk("dual_count0", {29'd0, count}, 32'd0);
    chk("dual_updv0", {31'd0, upd_valid}, 32'd0);
    upd_ready = 1'b0;
    drive0(1'b1, '{32'h10, 32'h1010, 1'b0, 1'b1, 1'b0}, 1'b1);
    drive1(1'b1, '{32'h14, 32'h1014, 1'b1, 1'b1, 1'b1}, 1'b1);
    tick();
    chk("fill_count2", {29'd0, count}, 32'd2);
    chk("fill_ready2", {31'd0, res_ready}, 32'd1);
    drive0(1'b1, '{32'h18, 32'h1018, 1'b1, 1'b0, 1'b1}, 1'b1);
    drive1(1'b1, '{32'h1c, 32'h101c, 1'b0, 1'b1, 1'b0}, 1'b1);
    tick();
    chk("full_count", {29'd0, count}, 32'd4);
    chk("full_ready", {31'd0, res_ready}, 32'd0);
    chk("full_drop_pre", {31'd0, drop}, 32'd0);
    drive0(1'b1, '{32'hbad0, 32'h0, 1'b1, 1'b1, 1'b1}, 1'b0);
    drive1(1'b1, '{32'hbad4, 32'h0, 1'b1, 1'b1, 1'b1}, 1'b0);
    tick();
    idle();
    chk("full_drop", {31'd0, drop}, 32'd1);
    chk("full_count_hold", {29'd0, count}, 32'd4);
    tick();
    chk("full_drop_off", {31'd0, drop}, 32'd0);
    chk("full_head", upd_pc, 32'h10);
    upd_ready = 1'b1;
    tick();
    upd_ready = 1'b0;
    chk("c3_count", {29'd0, count}, 32'd3);
    chk("c3_ready", {31'd0, res_ready}, 32'd0);
    clear = 1'b1;
    drive0(1'b1, '{32'hdead, 32'hbeef, 1'b1, 1'b1, 1'b1}, 1'b0);
    tick();
    clear = 1'b0;
    idle();
    sb.delete();
    chk("flush_count", {29'd0, count}, 32'd0);
    chk("flush_drop", {31'd0, drop}, 32'd1);
    run_clear("clr1");
    chk("clr1_updv", {31'd0, upd_valid}, 32'd0);
    drive0(1'b1, '{32'h20, 32'h2020, 1'b1, 1'b1, 1'b0}, 1'b1);
    drive1(1'b1, '{32'h24, 32'h2024, 1'b0, 1'b0, 1'b1}, 1'b1);
    tick();
    chk("pp_count2", {29'd0, count}, 32'd2);
    upd_ready = 1'b1;
    idle();
    drive1(1'b1, '{32'h28, 32'h2028, 1'b0, 1'b0, 1'b0}, 1'b1);
    tick();
    idle();
    chk("pp_count_hold", {29'd0, count}, 32'd2);
    chk("pp_head", upd_pc, 32'h24);
    tick();
    tick();
    chk("pp_count0", {29'd0, count}, 32'd0);
    upd_ready = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    chk("mid_idx7", {28'd0, clr_idx}, 32'd7);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    run_clear("clr2");
    chk("sb_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
